// File: rtl/d_branch_pred_cmp_pkg.sv
// Shared constants for the D-stage branch resolver: MIPS branch opcodes,
// REGIMM rt selectors and the 2-bit saturating counter encodings.
package d_branch_pred_cmp_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && cur != ST)
      nxt = cur + 2'd1;
    else if (!taken && cur != SNT)
      nxt = cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/d_branch_pred_cmp_cond.sv
// Combinational decode and compare for the six MIPS conditional branches.
// Zero-compare branches look only at the sign and zero-ness of left.
module d_branch_cond
  import d_branch_pred_cmp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic              is_branch,
  output logic              branch_taken
);

  logic left_neg;
  logic left_zero;

  assign left_neg  = left[DATA_W-1];
  assign left_zero = (left == '0);

  always_comb begin
    is_branch    = 1'b0;
    branch_taken = 1'b0;
    case (opcode)
      OP_BEQ: begin
        is_branch    = 1'b1;
        branch_taken = (left == right);
      end
      OP_BNE: begin
        is_branch    = 1'b1;
        branch_taken = (left != right);
      end
      OP_BLEZ: begin
        is_branch    = 1'b1;
        branch_taken = left_neg | left_zero;
      end
      OP_BGTZ: begin
        is_branch    = 1'b1;
        branch_taken = ~left_neg & ~left_zero;
      end
      OP_REGIMM: begin
        if (rt == RT_BGEZ) begin
          is_branch    = 1'b1;
          branch_taken = ~left_neg;
        end else if (rt == RT_BLTZ) begin
          is_branch    = 1'b1;
          branch_taken = left_neg;
        end
      end
      default: begin
        is_branch    = 1'b0;
        branch_taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/d_branch_pred_cmp.sv
// D-stage branch resolver with a 2-bit saturating pattern-history predictor.
// Optional BRANCH_STATS_EN adds resolve/mispredict counters br_count, mp_count.
module d_branch_pred_cmp
  import d_branch_pred_cmp_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         PHT_DEPTH  = 64,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       f_pc,
  output logic              f_pred_taken,
  input  logic              d_valid,
  input  logic              d_stall,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_instr,
  input  logic              d_pred_taken,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic              is_branch,
  output logic              branch_taken,
  output logic              mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       br_count,
  output logic [31:0]       mp_count
`endif
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [1:0]       pht [PHT_DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] d_idx;
  logic             resolve;

  d_branch_cond #(.DATA_W(DATA_W)) u_cond (
    .opcode       (d_instr[31:26]),
    .rt           (d_instr[20:16]),
    .left         (left),
    .right        (right),
    .is_branch    (is_branch),
    .branch_taken (branch_taken)
  );

  assign f_idx = f_pc[IDX_W+1:2];
  assign d_idx = d_pc[IDX_W+1:2];

  // d_valid qualifies the D instruction; d_stall freezes it, so a branch
  // resolves (and trains) only on a cycle that is valid, not stalled, not reset.
  assign resolve    = d_valid & is_branch & ~d_stall & ~reset;
  assign mispredict = resolve & (branch_taken ^ d_pred_taken);

  // Reading the array directly returns the pre-update value on same-index collisions.
  assign f_pred_taken = reset ? INIT_STATE[1] : pht[f_idx][1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_DEPTH; i++)
        pht[i] <= INIT_STATE;
    end else if (resolve) begin
      pht[d_idx] <= ctr_next(pht[d_idx], branch_taken);
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (resolve)
        br_count <= br_count + 32'd1;
      if (mispredict)
        mp_count <= mp_count + 32'd1;
    end
  end
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], f_pc[31:IDX_W+2], d_pc[1:0], d_pc[31:IDX_W+2],
                            d_instr[25:21], d_instr[15:0]};

endmodule

// File: tb/tb_d_branch_pred_cmp.sv
// Directed bench for d_branch_pred_cmp; checks resolve, prediction training,
// stall/invalid gating, aliasing and reset (plus counters under BRANCH_STATS_EN).
module tb_d_branch_pred_cmp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] f_pc = 32'h0;
  logic        f_pred_taken;
  logic        d_valid = 1'b0;
  logic        d_stall = 1'b0;
  logic [31:0] d_pc = 32'h0;
  logic [31:0] d_instr = 32'h0;
  logic        d_pred_taken = 1'b0;
  logic [31:0] left = 32'h0;
  logic [31:0] right = 32'h0;
  logic        is_branch;
  logic        branch_taken;
  logic        mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mp_count;
`endif

  int checks = 0;
  int failures = 0;

  d_branch_pred_cmp dut (
    .clk          (clk),
    .reset        (reset),
    .f_pc         (f_pc),
    .f_pred_taken (f_pred_taken),
    .d_valid      (d_valid),
    .d_stall      (d_stall),
    .d_pc         (d_pc),
    .d_instr      (d_instr),
    .d_pred_taken (d_pred_taken),
    .left         (left),
    .right        (right),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .mispredict   (mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .br_count     (br_count),
    .mp_count     (mp_count)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd3, rt, 16'h0010};
  endfunction

  // Driver: applies one D-stage instruction after the falling edge.
  task automatic drive(input logic v, input logic s, input logic [31:0] pc,
                       input logic [31:0] instr, input logic pred,
                       input logic [31:0] l, input logic [31:0] r);
    @(negedge clk);
    d_valid = v; d_stall = s; d_pc = pc; d_instr = instr;
    d_pred_taken = pred; left = l; right = r;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    f_pc = 32'h0000_3000;
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h3000, ins(6'b000100, 5'd0), 1'b0, 32'd5, 32'd5);
    drive(1'b1, 1'b0, 32'h3000, ins(6'b000100, 5'd0), 1'b0, 32'd5, 32'd5);
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", f_pred_taken); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
    @(negedge clk);
    reset = 1'b0;
    d_valid = 1'b0;
    #1;
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL post_reset_pred got=%b exp=0", f_pred_taken); end
`ifdef BRANCH_STATS_EN
    checks++; if (br_count !== 32'd0) begin failures++; $display("FAIL reset_br_count got=%0d exp=0", br_count); end
    checks++; if (mp_count !== 32'd0) begin failures++; $display("FAIL reset_mp_count got=%0d exp=0", mp_count); end
`endif
  endtask

  task automatic test_beq();
    f_pc = 32'h0000_3000;
    drive(1'b1, 1'b0, 32'h3000, ins(6'b000100, 5'd0), 1'b0, 32'd5, 32'd5);
    checks++; if (is_branch !== 1'b1) begin failures++; $display("FAIL beq_is_branch got=%b exp=1", is_branch); end
    checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", branch_taken); end
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL beq_mispredict got=%b exp=1", mispredict); end
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL beq_pre_update got=%b exp=0", f_pred_taken); end
    idle();
    checks++; if (f_pred_taken !== 1'b1) begin failures++; $display("FAIL beq_post_update got=%b exp=1", f_pred_taken); end
`ifdef BRANCH_STATS_EN
    checks++; if (br_count !== 32'd1) begin failures++; $display("FAIL beq_br_count got=%0d exp=1", br_count); end
    checks++; if (mp_count !== 32'd1) begin failures++; $display("FAIL beq_mp_count got=%0d exp=1", mp_count); end
`endif
  endtask

  task automatic test_bne_saturate();
    f_pc = 32'h0000_3004;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h3004, ins(6'b000101, 5'd0), 1'b1, 32'd1, 32'd2);
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL bne_taken[%0d] got=%b exp=1", i, branch_taken); end
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL bne_no_mp[%0d] got=%b exp=0", i, mispredict); end
    end
    drive(1'b1, 1'b0, 32'h3004, ins(6'b000101, 5'd0), 1'b1, 32'd7, 32'd7);
    checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL bne_not_taken got=%b exp=0", branch_taken); end
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL bne_mp got=%b exp=1", mispredict); end
    idle();
    checks++; if (f_pred_taken !== 1'b1) begin failures++; $display("FAIL bne_after_dec got=%b exp=1", f_pred_taken); end
    drive(1'b1, 1'b0, 32'h3004, ins(6'b000101, 5'd0), 1'b0, 32'd7, 32'd7);
    idle();
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL bne_after_dec2 got=%b exp=0", f_pred_taken); end
  endtask

  task automatic test_zero_cmp();
    logic [31:0] t_ins [10];
    logic [31:0] t_l   [10];
    logic [31:0] t_r   [10];
    logic        t_br  [10];
    logic        t_tk  [10];
    t_ins[0] = ins(6'b000001, 5'd0); t_l[0] = 32'h8000_0000; t_r[0] = 32'h8000_0000; t_br[0] = 1; t_tk[0] = 1;
    t_ins[1] = ins(6'b000111, 5'd0); t_l[1] = 32'h0;         t_r[1] = 32'hFFFF_FFFF; t_br[1] = 1; t_tk[1] = 0;
    t_ins[2] = ins(6'b000110, 5'd0); t_l[2] = 32'h0;         t_r[2] = 32'h0000_0005; t_br[2] = 1; t_tk[2] = 1;
    t_ins[3] = ins(6'b000001, 5'd1); t_l[3] = 32'h0;         t_r[3] = 32'h1234_5678; t_br[3] = 1; t_tk[3] = 1;
    t_ins[4] = ins(6'b000111, 5'd0); t_l[4] = 32'h8000_0000; t_r[4] = 32'h0;         t_br[4] = 1; t_tk[4] = 0;
    t_ins[5] = ins(6'b000110, 5'd0); t_l[5] = 32'h1;         t_r[5] = 32'h1;         t_br[5] = 1; t_tk[5] = 0;
    t_ins[6] = ins(6'b000001, 5'd0); t_l[6] = 32'h1;         t_r[6] = 32'hFFFF_FFFF; t_br[6] = 1; t_tk[6] = 0;
    t_ins[7] = ins(6'b000001, 5'd2); t_l[7] = 32'h8000_0000; t_r[7] = 32'h0;         t_br[7] = 0; t_tk[7] = 0;
    t_ins[8] = ins(6'b000000, 5'd0); t_l[8] = 32'h9;         t_r[8] = 32'h9;         t_br[8] = 0; t_tk[8] = 0;
    t_ins[9] = ins(6'b000100, 5'd0); t_l[9] = 32'h5;         t_r[9] = 32'h6;         t_br[9] = 1; t_tk[9] = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h3008, t_ins[i], ~t_tk[i], t_l[i], t_r[i]);
      checks++; if (is_branch !== t_br[i]) begin failures++; $display("FAIL cond_is_branch[%0d] got=%b exp=%b", i, is_branch, t_br[i]); end
      checks++; if (branch_taken !== t_tk[i]) begin failures++; $display("FAIL cond_taken[%0d] got=%b exp=%b", i, branch_taken, t_tk[i]); end
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL cond_invalid_mp[%0d] got=%b exp=0", i, mispredict); end
    end
    f_pc = 32'h0000_300C;
    drive(1'b1, 1'b0, 32'h300C, ins(6'b000100, 5'd0), 1'b1, 32'd3, 32'd3);
    drive(1'b1, 1'b0, 32'h300C, ins(6'b000001, 5'd2), 1'b1, 32'h8000_0000, 32'd0);
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL regimm_bad_mp got=%b exp=0", mispredict); end
    drive(1'b1, 1'b0, 32'h300C, ins(6'b000000, 5'd0), 1'b1, 32'd0, 32'd1);
    idle();
    checks++; if (f_pred_taken !== 1'b1) begin failures++; $display("FAIL nonbranch_table got=%b exp=1", f_pred_taken); end
  endtask

  task automatic test_stall();
    f_pc = 32'h0000_3010;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h3010, ins(6'b000100, 5'd0), 1'b0, 32'd4, 32'd4);
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL stall_mp[%0d] got=%b exp=0", i, mispredict); end
      checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL stall_table[%0d] got=%b exp=0", i, f_pred_taken); end
    end
    drive(1'b1, 1'b0, 32'h3010, ins(6'b000100, 5'd0), 1'b0, 32'd4, 32'd4);
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL stall_release_pre got=%b exp=0", f_pred_taken); end
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL stall_release_mp got=%b exp=1", mispredict); end
    idle();
    checks++; if (f_pred_taken !== 1'b1) begin failures++; $display("FAIL stall_single_update got=%b exp=1", f_pred_taken); end
    drive(1'b1, 1'b0, 32'h3010, ins(6'b000100, 5'd0), 1'b0, 32'd4, 32'd5);
    idle();
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL stall_one_step got=%b exp=0", f_pred_taken); end
    f_pc = 32'h0000_3014;
    drive(1'b0, 1'b0, 32'h3014, ins(6'b000100, 5'd0), 1'b0, 32'd4, 32'd4);
    idle();
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL invalid_no_update got=%b exp=0", f_pred_taken); end
  endtask

  task automatic test_same_cycle();
    f_pc = 32'h0000_3018;
    drive(1'b1, 1'b0, 32'h3018, ins(6'b000111, 5'd0), 1'b1, 32'd1, 32'd0);
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL same_cycle_pre got=%b exp=0", f_pred_taken); end
    idle();
    checks++; if (f_pred_taken !== 1'b1) begin failures++; $display("FAIL same_cycle_post got=%b exp=1", f_pred_taken); end
  endtask

  task automatic test_alias_reset();
    logic [31:0] pcs [5];
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h300C; pcs[3] = 32'h3018; pcs[4] = 32'h3100;
    f_pc = 32'h0000_3100;
    drive(1'b1, 1'b0, 32'h3000, ins(6'b000100, 5'd0), 1'b1, 32'd8, 32'd8);
    drive(1'b1, 1'b0, 32'h3000, ins(6'b000100, 5'd0), 1'b1, 32'd8, 32'd8);
    idle();
    checks++; if (f_pred_taken !== 1'b1) begin failures++; $display("FAIL alias_pred got=%b exp=1", f_pred_taken); end
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h3000, ins(6'b000100, 5'd0), 1'b1, 32'd8, 32'd9);
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_mid_mp got=%b exp=0", mispredict); end
    checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_mid_pred got=%b exp=0", f_pred_taken); end
    @(negedge clk);
    reset = 1'b0;
    d_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f_pc = pcs[i];
      #1;
      checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_clear[%0h] got=%b exp=0", pcs[i], f_pred_taken); end
    end
`ifdef BRANCH_STATS_EN
    checks++; if (br_count !== 32'd0) begin failures++; $display("FAIL reset2_br_count got=%0d exp=0", br_count); end
    checks++; if (mp_count !== 32'd0) begin failures++; $display("FAIL reset2_mp_count got=%0d exp=0", mp_count); end
`endif
    f_pc = 32'h0000_3000;
    drive(1'b1, 1'b0, 32'h3000, ins(6'b000100, 5'd0), 1'b0, 32'd1, 32'd1);
    idle();
    checks++; if (f_pred_taken !== 1'b1) begin failures++; $display("FAIL reset_init_weak got=%b exp=1", f_pred_taken); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bne_saturate();
    test_zero_cmp();
    test_stall();
    test_same_cycle();
    test_alias_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d_branch_pred_cmp.md
# d_branch_pred_cmp

Decode-stage branch resolver with a parametrised pattern-history predictor, the successor to the beq/bne-only D-stage comparator. It resolves all six MIPS conditional branches (beq, bne, blez, bgtz, bgez, bltz) on forwarded operands. It supplies a fetch-stage taken/not-taken prediction from a table of 2-bit saturating counters. It flags a mispredict when the D-stage outcome disagrees with the prediction carried down from F, and trains the table on every resolved branch.

## Interface
- DATA_W, 32, operand width
- PHT_DEPTH, 64, counter entries; power of two, ≥ 2
- IDX_W, $clog2(PHT_DEPTH), index width; derived, not overridden
- INIT_STATE, 2'b01, counter value after reset (weakly not-taken)

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- f_pc  in  32  fetch PC for lookup
- f_pred_taken  out  1  prediction for f_pc
- d_valid  in  1  D stage holds a real instruction
- d_stall  in  1  D stage frozen this cycle
- d_pc  in  32  PC of D instruction
- d_instr  in  32  D instruction word
- d_pred_taken  in  1  prediction made for this instruction in F
- left  in  DATA_W  forwarded rs value
- right  in  DATA_W  forwarded rt value
- is_branch  out  1  d_instr is a recognised conditional branch
- branch_taken  out  1  resolved outcome
- mispredict  out  1  outcome ≠ d_pred_taken; redirect/flush request

## Operation
- Decode uses d_instr[31:26]:
  - 000100 beq: left==right
  - 000101 bne: left!=right
  - 000110 blez: signed left≤0
  - 000111 bgtz: signed left>0
  - 000001 with rt (d_instr[20:16]) 00001 bgez: signed left≥0
  - 000001 with rt 00000 bltz: signed left<0
  - Any other opcode, or 000001 with any other rt: is_branch=0, branch_taken=0.
- `right` is ignored for zero-compare branches.
- Index = pc[IDX_W+1:2]. Aliasing every 4·PHT_DEPTH bytes is accepted.
- f_pred_taken = PHT[idx(f_pc)][1].
- A resolve event is d_valid & is_branch & ~d_stall & ~reset.
- mispredict = resolve event & (branch_taken ^ d_pred_taken). It is 0 otherwise, including while stalled.
- On a resolve event, PHT[idx(d_pc)] updates at the next rising edge: taken increments, saturating at 11; not-taken decrements, saturating at 00.
- Non-branches, stalled cycles and invalid cycles never modify the table.

## Timing
- is_branch, branch_taken, mispredict and f_pred_taken are combinational; latency 0 from inputs.
- Counter update is visible one cycle after the resolve edge.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update value.
- Reset:
  - Every entry becomes INIT_STATE in the cycle reset is sampled.
  - During reset, f_pred_taken=INIT_STATE[1], mispredict=0, and no update occurs.
  - Reset asserted mid-stall or mid-resolve: reset wins and the pending update is discarded.
- Outputs are driven purely by inputs and table state; none has a separate reset value beyond the above.

## Configuration
- BRANCH_STATS_EN:
  - Defined: adds outputs br_count[31:0] and mp_count[31:0].
    - br_count increments on every resolve event.
    - mp_count increments when mispredict=1.
    - Both clear to 0 on reset and wrap modulo 2^32.
  - Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - opcode constants OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM
  - RT_BGEZ, RT_BLTZ
  - 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11
- Sub-module d_branch_cond: purely combinational decode and compare, producing is_branch and branch_taken.
- Top level holds the PHT register array, update logic, mispredict logic and optional stats.

## Test plan
- Reset, then f_pc=0x00003000 → f_pred_taken=0. With BRANCH_STATS_EN, br_count=mp_count=0.
- Cycle 1: beq, left=right=5, d_pred_taken=0, d_pc=0x3000 → branch_taken=1, mispredict=1. Cycle 2: lookup 0x3000 → f_pred_taken=1 (entry 10).
- Three taken bne at 0x3004 (left=1, right=2) → entry 11. Fourth update, not-taken (left=right) → entry 10, prediction still 1.
- Zero-compare cases:
  - bltz left=0x80000000 → taken.
  - bgtz left=0 → not taken.
  - blez left=0 → taken.
  - Opcode 000001 with rt=00010 → is_branch=0, no table change.
- Taken beq with d_stall=1, held for 3 cycles → mispredict=0, table unchanged. Release stall → single update.
- Aliasing: train 0x3000 taken twice with PHT_DEPTH=64 → lookup 0x3100 predicts taken. Assert reset mid-sequence → all lookups return 0 next cycle.
